// File: rtl/present_mask_pkg.sv
// present_mask_pkg: shared widths, share count, FSM states and per-share affine constants
package present_mask_pkg;
    localparam int NIBBLE_W = 4;
    localparam int SHARES = 3;
    localparam logic [SHARES-1:0] C = 3'b001;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/inv_affine_nib.sv
// inv_affine_nib: per-share 4-bit inverse of the masked S-box output affine map
module inv_affine_nib #(
    parameter logic C_SEL = 1'b0
) (
    input  logic [3:0] y,
    output logic [3:0] x
);
    assign x = {y[1], y[3] ^ y[2] ^ C_SEL, y[2], y[0]};
endmodule

// File: rtl/masked_inv_affine_layer.sv
// masked_inv_affine_layer: nibble-serial 3-share inverse output affine over a full state
module masked_inv_affine_layer
    import present_mask_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_s1,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_s2,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_s3,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_s1,
    output logic [NIBBLE_W*NIBBLES-1:0] out_s2,
    output logic [NIBBLE_W*NIBBLES-1:0] out_s3
);
    localparam int W = NIBBLE_W * NIBBLES;
    localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic [W-1:0] sh [SHARES];
    logic [NIBBLE_W-1:0] nib [SHARES];
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        inv_affine_nib #(.C_SEL(C[i])) u_nib (.y(sh[i][NIBBLE_W-1:0]), .x(nib[i]));
    end
    // Each share rotates right by one nibble with its transformed low nibble entering at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            for (int k = 0; k < SHARES; k++) sh[k] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh[0] <= in_s1;
                    sh[1] <= in_s2;
                    sh[2] <= in_s3;
                    cnt <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    for (int k = 0; k < SHARES; k++) sh[k] <= {nib[k], sh[k][W-1:NIBBLE_W]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NIBBLES - 1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out_s1 = sh[0];
    assign out_s2 = sh[1];
    assign out_s3 = sh[2];
endmodule

// File: tb/tb_masked_inv_affine_layer.sv
// tb_masked_inv_affine_layer: scoreboard bench for the 3-share inverse affine layer
module tb_masked_inv_affine_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [63:0] in_s1 = '0, in_s2 = '0, in_s3 = '0;
    logic [63:0] out_s1, out_s2, out_s3;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;

    typedef struct {
        logic [63:0] s1, s2, s3;
        int acc;
    } exp_t;
    exp_t exp_q[$];

    masked_inv_affine_layer #(.NIBBLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Forward affine map, independent of the block under test
    function automatic logic [63:0] fwd(input logic [63:0] x, input logic c);
        logic [63:0] r;
        logic [3:0] n;
        for (int i = 0; i < 16; i++) begin
            n = x[4*i +: 4];
            r[4*i +: 4] = {n[1] ^ n[2] ^ c, n[1], n[3], n[0]};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_s1", out_s1, e.s1);
                chk("out_s2", out_s2, e.s2);
                chk("out_s3", out_s3, e.s3);
                chk("latency", 64'(cyc - e.acc), 64'd16);
            end
        end
        prev_ov = out_valid;
    end

    task automatic run(input logic [63:0] a, b, c, ea, eb, ec, input int hold, input bit noise);
        int n;
        logic [63:0] o1, o2, o3;
        @(negedge clk);
        in_s1 = a; in_s2 = b; in_s3 = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("accept_timeout", 64'd0, 64'd1); in_valid = 1'b0; return; end
        @(negedge clk);
        exp_q.push_back('{ea, eb, ec, cyc});
        in_valid = 1'b0;
        if (noise) begin
            repeat (3) @(negedge clk);
            in_s1 = ~a; in_s2 = ~b; in_s3 = 64'h1234_5678_9abc_def0; in_valid = 1'b1;
            repeat (2) @(negedge clk);
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) begin chk("done_timeout", 64'd0, 64'd1); return; end
        o1 = out_s1; o2 = out_s2; o3 = out_s3;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_s1", out_s1, o1);
            chk("hold_s2", out_s2, o2);
            chk("hold_s3", out_s3, o3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] x, m2, m3;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_s1", out_s1, 64'd0);
        chk("reset_s2", out_s2, 64'd0);
        chk("reset_s3", out_s3, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(64'd0, 64'd0, 64'd0, 64'h4444444444444444, 64'd0, 64'd0, 0, 1'b0);
        run(64'd0, '1, 64'd0, 64'h4444444444444444, 64'hBBBBBBBBBBBBBBBB, 64'd0, 10, 1'b0);
        run(64'd0, 64'd0, 64'd0, 64'h4444444444444444, 64'd0, 64'd0, 0, 1'b1);

        // Aborted transfer: reset in the middle of BUSY must discard it
        @(negedge clk);
        in_s1 = '1; in_s2 = 64'h0f0f0f0f0f0f0f0f; in_s3 = 64'h1111111111111111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_s1", out_s1, 64'd0);
        chk("abort_s2", out_s2, 64'd0);
        chk("abort_s3", out_s3, 64'd0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_load", out_s1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(64'd0, '1, 64'd0, 64'h4444444444444444, 64'hBBBBBBBBBBBBBBBB, 64'd0, 0, 1'b0);

        for (int v = 0; v < 1000; v++) begin
            x = {$urandom, $urandom};
            m2 = {$urandom, $urandom};
            m3 = {$urandom, $urandom};
            run(fwd(x ^ m2 ^ m3, 1'b1), fwd(m2, 1'b0), fwd(m3, 1'b0), x ^ m2 ^ m3, m2, m3, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/masked_inv_affine_layer.md
# masked_inv_affine_layer

Nibble-serial, 3-share inverse of the PRESENT masked-S-box output affine stage, applied to a full 64-bit state. It sits in the decryption datapath in front of the shared inverse-S-box core. It accepts one 3-share state through a valid/ready handshake, processes one nibble per cycle with each share kept in its own register, and returns the 3-share result through a second valid/ready handshake.

## Interface
- NIBBLES, 16: number of 4-bit nibbles per share; state width is 4*NIBBLES.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input state shares valid.
- in_ready  output  1  block can accept a state; high exactly in IDLE.
- in_s1, in_s2, in_s3  input  4*NIBBLES  input shares; unmasked value = XOR of the three.
- out_valid  output  1  result shares valid; high exactly in DONE.
- out_ready  input  1  consumer accepts the result.
- out_s1, out_s2, out_s3  output  4*NIBBLES  result shares, driven directly by the share registers.

## Operation
- Per-nibble inverse map for share k, with input y[3:0] and output x[3:0]: x = {y[1], y[3]^y[2]^c, y[2], y[0]}.
  - c = 1 for share 1 (XNOR); c = 0 for shares 2 and 3.
  - This exactly inverts the forward map {x1~^x2 or x1^x2, x1, x3, x0}.
- Shares never mix. Each share's next-state logic reads only that share's register.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid is high: load the three share registers, cnt<=0, go to BUSY.
  - BUSY: each cycle, every share register rotates right by 4. The transformed low nibble enters at the top. cnt increments. When cnt==NIBBLES-1, go to DONE. After NIBBLES rotations every nibble has been transformed once and is back in its original position.
  - DONE: out_valid=1. Share registers hold. When out_ready is high, go to IDLE.
- in_valid during BUSY or DONE is ignored. in_ready=0 in those states, so there is no back-to-back overlap.
- out_ready outside DONE is ignored.
- cnt is $clog2(NIBBLES) bits wide and compares against NIBBLES-1, so wrap-around never occurs.
- Nibble 0 is bits [3:0]. Nibble order does not affect the result, because the map is nibble-local.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, all share registers = 0.
  - Outputs: out_valid=0, out_s*=0, in_ready=1. No load can occur while rst_n is low.
- Latency:
  - Accept edge T (in_valid & in_ready).
  - BUSY occupies the edges T+1 .. T+NIBBLES.
  - out_valid is high from edge T+NIBBLES onwards, i.e. 16 cycles for the default.
- Throughput: at most one state per NIBBLES+2 cycles.
  - Release edge (out_valid & out_ready) -> IDLE; in_ready rises at that edge.
  - The earliest new accept is one cycle later.
- While in BUSY, out_s* show partially rotated data and are undefined for consumers. They are valid only while out_valid is high.
- Reset mid-BUSY or mid-DONE: immediate return to the reset values above. The in-flight state is discarded and produces no out_valid pulse.
- Output stability: while out_valid=1 and out_ready=0, out_s* must hold constant.

## Structure
- Shared package present_mask_pkg holds:
  - NIBBLE_W=4, SHARES=3, the state enum {IDLE, BUSY, DONE};
  - share-constant vector C = 3'b001, where share 1 carries the affine constant.
- Sub-module inv_affine_nib: combinational 4-bit map with a constant-select parameter. It is instantiated once per share on that share's low nibble.
- Top level holds the FSM, cnt, the three share registers and the handshake logic.

## Test plan
- All shares 0 -> after 16 cycles, out_s1=64'h4444444444444444, out_s2=out_s3=0.
- in_s1=0, in_s2=64'hFFFFFFFFFFFFFFFF, in_s3=0 -> out_s1=64'h4444...4, out_s2=64'hBBBB...B, out_s3=0. The XOR of the outputs is 64'hFFFF...F, which matches the unshared inverse of F (=F).
- Round trip: random x with random masks m2, m3, passed through the forward affine then this block -> XOR of the output shares equals x. Also check out_s2 and out_s3 individually against the per-share inverse of their inputs, across 1000 vectors.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_s* stay stable, in_ready stays 0. Assert out_ready -> IDLE on the next edge.
- Ignored traffic: pulse in_valid with new data during BUSY -> result unaffected, and the latency from the original accept is exactly 16.
- Async reset at cycle 8 of BUSY -> outputs immediately zero, in_ready=1, no out_valid. A fresh accept afterwards completes normally.
